// File: rtl/gt_pkt_pkg.sv
// Shared constants and types for the GT packet generator.
// K-characters, payload mode encodings and FSM states.
package gt_pkt_pkg;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOP  = 8'hFB;
  localparam logic [7:0] K_EOP  = 8'hFD;
  localparam logic [7:0] D_FILL = 8'h50;

  localparam logic [30:0] PRBS_SEED = 31'h7FFFFFFF;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_FIXED = 2'd2,
    MODE_EXT   = 2'd3
  } mode_e;

  // State names the word currently on gt_tx_*.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOP  = 2'd1,
    ST_DATA = 2'd2,
    ST_EOP  = 2'd3
  } state_e;

endpackage

// File: rtl/gt_packet_gen_prbs.sv
// Parallel PRBS31 (x^31+x^28+1), W bits per step, LSB first.
// data shows the next W bits; adv commits them, load reseeds.
module gt_prbs31_par
  import gt_pkt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] data
);

  logic [30:0]  lfsr;
  logic [30:0]  lfsr_nxt;
  logic [W-1:0] bits;

  always_comb begin
    lfsr_nxt = lfsr;
    bits     = '0;
    for (int i = 0; i < W; i++) begin
      bits[i]  = lfsr_nxt[30] ^ lfsr_nxt[27];
      lfsr_nxt = {lfsr_nxt[29:0], bits[i]};
    end
  end

  assign data = bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= PRBS_SEED;
    end else if (load) begin
      lfsr <= PRBS_SEED;
    end else if (adv) begin
      lfsr <= lfsr_nxt;
    end
  end

endmodule

// File: rtl/gt_packet_gen.sv
// Packet framer for one 8b/10b GT TX lane: SOP, payload, EOP
// with sequence number and XOR checksum, comma idles in between.
module gt_packet_gen
  import gt_pkt_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int LEN_W       = 16,
  parameter int MIN_IDLE    = 4,
  parameter int PRBS_RESEED = 1,
  localparam int DW         = 8 * DATA_BYTES
) (
  input  logic                  tx_clk,
  input  logic                  rst,
  input  logic                  pkt_req,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic [7:0]            pkt_type,
  input  logic [1:0]            pkt_mode,
  input  logic [DW-1:0]         fixed_word,
  input  logic [DW-1:0]         ext_data,
  output logic                  ext_rd,
  output logic                  pkt_done,
  output logic                  busy,
  output logic [31:0]           pkt_cnt,
  output logic [DW-1:0]         gt_tx_data,
  output logic [DATA_BYTES-1:0] gt_tx_ctrl
);

  localparam int GW = $clog2(MIN_IDLE + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(MIN_IDLE);
  localparam logic [DATA_BYTES-1:0] K_FLAG = DATA_BYTES'(1);
  localparam logic [DW-1:0] IDLE_W =
    {{(DATA_BYTES-1){D_FILL}}, K_IDLE};

  state_e           state;
  state_e           nxt;
  mode_e            mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      seq;
  logic [GW-1:0]    gap;
  logic [DW-1:8]    csum;

  logic             start;
  logic             load_pay;
  logic             load_eop;
  logic             rd_d;
  logic [DW-1:0]    pay;
  logic [DW-1:0]    prbs_w;
  logic [DW-1:0]    sop_w;
  logic [DW-1:0]    eop_w;

  gt_prbs31_par #(
    .W(DW)
  ) u_prbs (
    .clk  (tx_clk),
    .rst  (rst),
    .load (start && (PRBS_RESEED != 0)),
    .adv  (load_pay && mode_q == MODE_PRBS),
    .data (prbs_w)
  );

  assign sop_w = (DW'(seq) << 16)
               | (DW'(pkt_type) << 8)
               | DW'(K_SOP);
  assign eop_w = {csum, K_EOP};

  always_comb begin
    pay = '0;
    unique case (mode_q)
      MODE_CNT:   pay = {DATA_BYTES{cnt[7:0]}};
      MODE_PRBS:  pay = prbs_w;
      MODE_FIXED: pay = fixed_word;
      MODE_EXT:   pay = ext_data;
      default:    pay = '0;
    endcase
  end

  always_comb begin
    nxt      = state;
    start    = 1'b0;
    load_pay = 1'b0;
    load_eop = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pkt_req && gap >= GAP_MAX) begin
          nxt   = ST_SOP;
          start = 1'b1;
        end
      end
      ST_SOP: begin
        if (len_q == '0) begin
          nxt      = ST_EOP;
          load_eop = 1'b1;
        end else begin
          nxt      = ST_DATA;
          load_pay = 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == len_q) begin
          nxt      = ST_EOP;
          load_eop = 1'b1;
        end else begin
          load_pay = 1'b1;
        end
      end
      ST_EOP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // ext_rd is registered, so predict whether next cycle loads ext_data.
  always_comb begin
    rd_d = 1'b0;
    if (start) begin
      rd_d = (mode_e'(pkt_mode) == MODE_EXT)
          && (pkt_len != '0);
    end else if (nxt == ST_DATA) begin
      rd_d = (mode_q == MODE_EXT)
          && ((cnt + LEN_W'(1)) != len_q);
    end
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      gt_tx_data <= IDLE_W;
      gt_tx_ctrl <= K_FLAG;
      ext_rd     <= 1'b0;
      pkt_done   <= 1'b0;
      busy       <= 1'b0;
      pkt_cnt    <= '0;
      seq        <= '0;
      gap        <= GAP_MAX;
      len_q      <= '0;
      mode_q     <= MODE_CNT;
      cnt        <= '0;
      csum       <= '0;
    end else begin
      busy     <= (nxt != ST_IDLE);
      ext_rd   <= rd_d;
      pkt_done <= (state == ST_EOP);
      if (state == ST_EOP) begin
        pkt_cnt <= pkt_cnt + 32'd1;
        seq     <= seq + 16'd1;
      end
      if (start) begin
        len_q      <= pkt_len;
        mode_q     <= mode_e'(pkt_mode);
        cnt        <= '0;
        csum       <= '0;
        gt_tx_data <= sop_w;
        gt_tx_ctrl <= K_FLAG;
      end else if (load_pay) begin
        cnt        <= cnt + LEN_W'(1);
        csum       <= csum ^ pay[DW-1:8];
        gt_tx_data <= pay;
        gt_tx_ctrl <= '0;
      end else if (load_eop) begin
        gap        <= '0;
        gt_tx_data <= eop_w;
        gt_tx_ctrl <= K_FLAG;
      end else begin
        if (gap != GAP_MAX) begin
          gap <= gap + GW'(1);
        end
        gt_tx_data <= IDLE_W;
        gt_tx_ctrl <= K_FLAG;
      end
    end
  end

endmodule

// File: tb/tb_gt_packet_gen.sv
// Scoreboard bench for gt_packet_gen: expected words are queued
// at request time and compared as the lane emits them.
module tb_gt_packet_gen;

  logic        tx_clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_req = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [7:0]  pkt_type = '0;
  logic [1:0]  pkt_mode = '0;
  logic [31:0] fixed_word = '0;
  logic [31:0] ext_data = '0;
  logic        ext_rd;
  logic        pkt_done;
  logic        busy;
  logic [31:0] pkt_cnt;
  logic [31:0] gt_tx_data;
  logic [3:0]  gt_tx_ctrl;

  always #5 tx_clk = ~tx_clk;

  gt_packet_gen #(
    .DATA_BYTES (4),
    .LEN_W      (16),
    .MIN_IDLE   (4),
    .PRBS_RESEED(1)
  ) dut (
    .tx_clk    (tx_clk),
    .rst       (rst),
    .pkt_req   (pkt_req),
    .pkt_len   (pkt_len),
    .pkt_type  (pkt_type),
    .pkt_mode  (pkt_mode),
    .fixed_word(fixed_word),
    .ext_data  (ext_data),
    .ext_rd    (ext_rd),
    .pkt_done  (pkt_done),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt),
    .gt_tx_data(gt_tx_data),
    .gt_tx_ctrl(gt_tx_ctrl)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  ctrl;
  } word_t;

  typedef struct {
    logic [1:0]  mode;
    int          len;
    logic [7:0]  typ;
    logic [31:0] fw;
    int          exp_rd;
  } vec_t;

  word_t       exp_q[$];
  bit          pq[$];
  logic [31:0] ext_vals[8];
  int n_cmp = 0;
  int n_bad = 0;
  int push_seq = 0;
  int exp_cnt = 0;
  int ext_push = 0;
  int ext_drv = 0;
  int rd_total = 0;
  int done_total = 0;
  int idle_run = 0;
  int last_gap = -1;
  bit prev_eop = 0;
  bit prev_busy = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  task automatic prbs_reset();
    pq.delete();
    repeat (31) pq.push_back(1'b1);
  endtask

  // b[n] = b[n-31] ^ b[n-28]; pq[0] is the oldest of the last 31 bits
  function automatic logic [31:0] prbs_word();
    logic [31:0] w;
    bit nb;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      nb = pq[0] ^ pq[3];
      void'(pq.pop_front());
      pq.push_back(nb);
      w[i] = nb;
    end
    return w;
  endfunction

  task automatic push_pkt(input logic [1:0] m, input int len,
                          input logic [7:0] t, input logic [31:0] fw);
    word_t e;
    logic [31:0] w;
    logic [31:0] cs;
    logic [7:0] kb;
    logic [15:0] s;
    s = push_seq[15:0];
    e.data = {s, t, 8'hFB};
    e.ctrl = 4'b0001;
    exp_q.push_back(e);
    prbs_reset();
    cs = '0;
    for (int k = 0; k < len; k++) begin
      kb = k[7:0];
      case (m)
        2'd0: w = {4{kb}};
        2'd1: w = prbs_word();
        2'd2: w = fw;
        default: begin
          w = ext_vals[ext_push % 8];
          ext_push++;
        end
      endcase
      e.data = w;
      e.ctrl = 4'b0000;
      exp_q.push_back(e);
      cs = cs ^ w;
    end
    e.data = {cs[31:8], 8'hFD};
    e.ctrl = 4'b0001;
    exp_q.push_back(e);
    push_seq++;
  endtask

  always @(negedge tx_clk) begin
    word_t w;
    if (rst) begin
      prev_eop  = 0;
      prev_busy = 0;
      idle_run  = 0;
    end else begin
      check("pkt_done_timing", pkt_done, prev_eop);
      prev_eop = 0;
      if (busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL word_unexpected: got %h expected none",
                   gt_tx_data);
        end else begin
          w = exp_q.pop_front();
          check("tx_data", gt_tx_data, w.data);
          check("tx_ctrl", gt_tx_ctrl, w.ctrl);
          prev_eop = (w.ctrl == 4'b0001) && (w.data[7:0] == 8'hFD);
        end
        if (!prev_busy) begin
          last_gap = idle_run;
          idle_run = 0;
        end
      end else begin
        check("idle_data", gt_tx_data, 32'h505050BC);
        check("idle_ctrl", gt_tx_ctrl, 4'b0001);
        idle_run++;
      end
      prev_busy = busy;
      if (ext_rd) begin
        rd_total++;
        ext_data = ext_vals[ext_drv % 8];
        ext_drv++;
      end
      if (pkt_done) done_total++;
    end
  end

  // which: 0 waits for busy, 1 waits for pkt_done
  task automatic wait_for(input int which, input int lim,
                          output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge tx_clk);
      if ((which == 0 && busy) || (which == 1 && pkt_done)) begin
        ok = 1;
        break;
      end
    end
    #1;
  endtask

  task automatic run_pkt(input logic [1:0] m, input int len,
                         input logic [7:0] t, input logic [31:0] fw,
                         input int exp_rd);
    int rd0;
    int d0;
    bit ok;
    rd0 = rd_total;
    d0 = done_total;
    push_pkt(m, len, t, fw);
    @(negedge tx_clk);
    #1;
    pkt_mode = m;
    pkt_len = 16'(len);
    pkt_type = t;
    fixed_word = fw;
    pkt_req = 1'b1;
    wait_for(0, 200, ok);
    if (!ok) fail_now("start");
    pkt_req = 1'b0;
    pkt_len = 16'($urandom);
    pkt_type = 8'($urandom);
    pkt_mode = 2'($urandom);
    wait_for(1, len + 50, ok);
    if (!ok) fail_now("done");
    exp_cnt++;
    check("pkt_cnt", pkt_cnt, exp_cnt);
    check("done_count", done_total - d0, 1);
    check("ext_rd_count", rd_total - rd0, exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    bit ok;
    ext_vals[0] = 32'h11223344;
    ext_vals[1] = 32'hA5A55A5A;
    ext_vals[2] = 32'h0F0F00FF;
    ext_vals[3] = 32'hCAFEF00D;
    ext_vals[4] = 32'h01234567;
    ext_vals[5] = 32'h89ABCDEF;
    ext_vals[6] = 32'hFFFF0000;
    ext_vals[7] = 32'h00FF00FF;
    tv[0] = '{2'd0, 5, 8'h01, 32'h0, 0};
    tv[1] = '{2'd1, 8, 8'h02, 32'h0, 0};
    tv[2] = '{2'd1, 8, 8'h03, 32'h0, 0};
    tv[3] = '{2'd2, 4, 8'h04, 32'hDEADBEEF, 0};
    tv[4] = '{2'd3, 3, 8'h05, 32'h0, 3};
    tv[5] = '{2'd0, 0, 8'h06, 32'h0, 0};
    tv[6] = '{2'd3, 0, 8'h07, 32'h0, 0};
    tv[7] = '{2'd2, 1, 8'hFF, 32'h12345678, 0};

    repeat (3) @(negedge tx_clk);
    #1 rst = 1'b0;
    check("rst_data", gt_tx_data, 32'h505050BC);
    check("rst_ctrl", gt_tx_ctrl, 4'b0001);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_busy", busy, 0);
    repeat (20) @(negedge tx_clk);
    #1;
    check("idle_ext_rd", rd_total, 0);
    check("idle_pkt_done", done_total, 0);

    // back-to-back with request held: gap must be exactly MIN_IDLE
    push_pkt(2'd0, 256, 8'h08, 32'h0);
    push_pkt(2'd0, 256, 8'h08, 32'h0);
    @(negedge tx_clk);
    #1;
    pkt_mode = 2'd0;
    pkt_len = 16'd256;
    pkt_type = 8'h08;
    pkt_req = 1'b1;
    wait_for(0, 100, ok);
    if (!ok) fail_now("b2b_start1");
    wait_for(1, 400, ok);
    if (!ok) fail_now("b2b_done1");
    wait_for(0, 100, ok);
    if (!ok) fail_now("b2b_start2");
    pkt_req = 1'b0;
    check("b2b_gap", last_gap, 4);
    wait_for(1, 400, ok);
    if (!ok) fail_now("b2b_done2");
    exp_cnt += 2;
    check("b2b_pkt_cnt", pkt_cnt, exp_cnt);

    for (int i = 0; i < 8; i++) begin
      run_pkt(tv[i].mode, tv[i].len, tv[i].typ, tv[i].fw,
              tv[i].exp_rd);
    end

    // reset while data word 5 is on the lane
    push_pkt(2'd0, 10, 8'h33, 32'h0);
    @(negedge tx_clk);
    #1;
    pkt_mode = 2'd0;
    pkt_len = 16'd10;
    pkt_type = 8'h33;
    pkt_req = 1'b1;
    wait_for(0, 100, ok);
    if (!ok) fail_now("rst_pkt_start");
    pkt_req = 1'b0;
    repeat (5) @(negedge tx_clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_data", gt_tx_data, 32'h505050BC);
    check("midrst_ctrl", gt_tx_ctrl, 4'b0001);
    check("midrst_busy", busy, 0);
    check("midrst_pkt_cnt", pkt_cnt, 0);
    check("midrst_ext_rd", ext_rd, 0);
    exp_q.delete();
    push_seq = 0;
    exp_cnt = 0;
    @(negedge tx_clk);
    #1 rst = 1'b0;
    run_pkt(2'd0, 2, 8'h44, 32'h0, 0);

    repeat (10) @(negedge tx_clk);
    #1;
    check("queue_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
